// File: rtl/piso_tx_sequencer.sv
// -----------------------------------------------------------------------------
// piso_tx_sequencer
//
// Controller for an external parallel-in/serial-out shift register. A 32-bit
// word is accepted from a valid/ready requester and presented on
// Parallel_Data_Out. Load_Shiftb_Out tells the PISO, which acts on the falling
// clock edge, whether to load the word or shift it right. The PISO's bit 0
// comes back on Serial_Bit_In. It is re-registered here on the rising edge and
// sent out LSB first as a frame of 1..32 bits.
//
// Optional feature: define PISO_TX_SEQUENCER_PARITY_EN to append one
// even-parity bit after the data bits. The parity bit is the XOR of the
// frame's data bits.
//
// Ports
//   Clk_In            in   1  clock; all state updates on the rising edge
//   Reset_In          in   1  asynchronous, active-high reset
//   Tx_Valid_In       in   1  requester offers a word
//   Tx_Data_In        in  32  word to serialise, LSB first
//   Frame_Len_In      in   6  bits per frame (0 or >32 means 32)
//   Abort_In          in   1  cancel the frame in progress
//   Serial_Bit_In     in   1  PISO serial output (shift register bit 0)
//   Tx_Ready_Out      out  1  controller idle, word can be accepted
//   Load_Shiftb_Out   out  1  PISO control: 1 = load, 0 = shift
//   Parallel_Data_Out out 32  captured word for the PISO parallel input
//   Serial_Data_Out   out  1  registered serial bit
//   Serial_Valid_Out  out  1  Serial_Data_Out carries a frame bit
//   Frame_Done_Out    out  1  pulse with the last bit of the frame
//   Busy_Out          out  1  frame in progress
//   Bit_Count_Out     out  6  index of the bit on Serial_Data_Out (0 when idle)
// -----------------------------------------------------------------------------
module piso_tx_sequencer (
  input  logic        Clk_In,
  input  logic        Reset_In,
  input  logic        Tx_Valid_In,
  input  logic [31:0] Tx_Data_In,
  input  logic [5:0]  Frame_Len_In,
  input  logic        Abort_In,
  input  logic        Serial_Bit_In,
  output logic        Tx_Ready_Out,
  output logic        Load_Shiftb_Out,
  output logic [31:0] Parallel_Data_Out,
  output logic        Serial_Data_Out,
  output logic        Serial_Valid_Out,
  output logic        Frame_Done_Out,
  output logic        Busy_Out,
  output logic [5:0]  Bit_Count_Out
);

`ifdef PISO_TX_SEQUENCER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_PARITY} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pdata_q, pdata_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sdata_q, sdata_d;
  logic        svalid_q, svalid_d;
  logic        done_q, done_d;
  logic        ld_q, ld_d;
  logic        busy_q, busy_d;
`ifdef PISO_TX_SEQUENCER_PARITY_EN
  logic        par_q, par_d;
`endif

  logic [5:0]  eff_len;   // frame length after clamping
  logic [5:0]  idx;       // index of the bit captured at this edge

  always_comb begin
    if (Frame_Len_In == 6'd0 || Frame_Len_In > 6'd32) eff_len = 6'd32;
    else                                              eff_len = Frame_Len_In;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case statement. An
    // unassigned path in always_comb would otherwise infer a latch.
    state_d  = state_q;
    pdata_d  = pdata_q;
    len_d    = len_q;
    cnt_d    = 6'd0;
    sdata_d  = 1'b0;
    svalid_d = 1'b0;
    done_d   = 1'b0;
    idx      = 6'd0;
`ifdef PISO_TX_SEQUENCER_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Abort_In is ignored here, so it never blocks an accept.
        if (Tx_Valid_In) begin
          pdata_d = Tx_Data_In;
          len_d   = eff_len;
          state_d = ST_LOAD;
`ifdef PISO_TX_SEQUENCER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end

      // The PISO has loaded at the falling edge inside LOAD, so bit 0 is
      // already on Serial_Bit_In at the LOAD->SHIFT edge. Capture starts
      // there, which gives one cycle of latency from accept to first bit.
      ST_LOAD, ST_SHIFT: begin
        if (Abort_In) begin
          state_d = ST_IDLE;
        end else begin
          idx      = (state_q == ST_LOAD) ? 6'd0 : cnt_q + 6'd1;
          sdata_d  = Serial_Bit_In;
          svalid_d = 1'b1;
          cnt_d    = idx;
`ifdef PISO_TX_SEQUENCER_PARITY_EN
          par_d    = par_q ^ Serial_Bit_In;
`endif
          if (idx == len_q - 6'd1) begin
`ifdef PISO_TX_SEQUENCER_PARITY_EN
            state_d = ST_PARITY;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

`ifdef PISO_TX_SEQUENCER_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
        if (!Abort_In) begin
          sdata_d  = par_q;
          svalid_d = 1'b1;
          cnt_d    = len_q;
          done_d   = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // The PISO must load while idle and during LOAD, and shift otherwise.
    ld_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: Reset_In is in the sensitivity list, so reset takes effect without
  // waiting for a clock edge.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q  <= ST_IDLE;
      pdata_q  <= 32'd0;
      len_q    <= 6'd32;
      cnt_q    <= 6'd0;
      sdata_q  <= 1'b0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
      ld_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef PISO_TX_SEQUENCER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge
      // values no matter what order the statements are in.
      state_q  <= state_d;
      pdata_q  <= pdata_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sdata_q  <= sdata_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
      ld_q     <= ld_d;
      busy_q   <= busy_d;
`ifdef PISO_TX_SEQUENCER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign Tx_Ready_Out      = (state_q == ST_IDLE);
  assign Load_Shiftb_Out   = ld_q;
  assign Parallel_Data_Out = pdata_q;
  assign Serial_Data_Out   = sdata_q;
  assign Serial_Valid_Out  = svalid_q;
  assign Frame_Done_Out    = done_q;
  assign Busy_Out          = busy_q;
  assign Bit_Count_Out     = cnt_q;

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_sequencer
//
// Self-checking bench for piso_tx_sequencer. The bench models the external
// PISO as a 32-bit register that loads or shifts right on the falling edge.
// Directed cases come from a vector table plus a few hand sequences. Random
// traffic is then checked against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_piso_tx_sequencer;

`ifdef PISO_TX_SEQUENCER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        Clk_In = 1'b0;
  logic        Reset_In;
  logic        Tx_Valid_In;
  logic [31:0] Tx_Data_In;
  logic [5:0]  Frame_Len_In;
  logic        Abort_In;
  logic        Serial_Bit_In;
  logic        Tx_Ready_Out;
  logic        Load_Shiftb_Out;
  logic [31:0] Parallel_Data_Out;
  logic        Serial_Data_Out;
  logic        Serial_Valid_Out;
  logic        Frame_Done_Out;
  logic        Busy_Out;
  logic [5:0]  Bit_Count_Out;

  int n_run  = 0;
  int n_fail = 0;

  piso_tx_sequencer dut (
    .Clk_In            (Clk_In),
    .Reset_In          (Reset_In),
    .Tx_Valid_In       (Tx_Valid_In),
    .Tx_Data_In        (Tx_Data_In),
    .Frame_Len_In      (Frame_Len_In),
    .Abort_In          (Abort_In),
    .Serial_Bit_In     (Serial_Bit_In),
    .Tx_Ready_Out      (Tx_Ready_Out),
    .Load_Shiftb_Out   (Load_Shiftb_Out),
    .Parallel_Data_Out (Parallel_Data_Out),
    .Serial_Data_Out   (Serial_Data_Out),
    .Serial_Valid_Out  (Serial_Valid_Out),
    .Frame_Done_Out    (Frame_Done_Out),
    .Busy_Out          (Busy_Out),
    .Bit_Count_Out     (Bit_Count_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // External PISO, acting on the falling edge.
  logic [31:0] piso_sr = 32'd0;
  always @(negedge Clk_In) begin
    if (Load_Shiftb_Out) piso_sr <= Parallel_Data_Out;
    else                 piso_sr <= {1'b0, piso_sr[31:1]};
  end
  assign Serial_Bit_In = piso_sr[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic busy,
                            input logic ld, input logic sv, input logic sd,
                            input logic done, input logic [5:0] cnt,
                            input logic [31:0] pd);
    check({tag, ".ready"}, {31'd0, Tx_Ready_Out},     {31'd0, rdy});
    check({tag, ".busy"},  {31'd0, Busy_Out},         {31'd0, busy});
    check({tag, ".ld"},    {31'd0, Load_Shiftb_Out},  {31'd0, ld});
    check({tag, ".valid"}, {31'd0, Serial_Valid_Out}, {31'd0, sv});
    check({tag, ".done"},  {31'd0, Frame_Done_Out},   {31'd0, done});
    check({tag, ".count"}, {26'd0, Bit_Count_Out},    {26'd0, cnt});
    check({tag, ".pdata"}, Parallel_Data_Out,         pd);
    if (sv) check({tag, ".bit"}, {31'd0, Serial_Data_Out}, {31'd0, sd});
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] data;
    logic [5:0]  len;
    logic        abort;
    logic        e_rdy, e_busy, e_ld, e_sv, e_sd, e_done;
    logic [5:0]  e_cnt;
    logic [31:0] e_pd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input string tag, input logic valid, input logic [31:0] data,
                             input logic [5:0] len, input logic abort,
                             input logic rdy, input logic busy, input logic ld,
                             input logic sv, input logic sd, input logic done,
                             input logic [5:0] cnt, input logic [31:0] pd);
    vec_t r;
    r.tag = tag; r.valid = valid; r.data = data; r.len = len; r.abort = abort;
    r.e_rdy = rdy; r.e_busy = busy; r.e_ld = ld; r.e_sv = sv; r.e_sd = sd;
    r.e_done = done; r.e_cnt = cnt; r.e_pd = pd;
    return r;
  endfunction

  // Frame-level reference model: expected outputs after each rising edge.
  logic        m_busy = 1'b0;
  int          m_phase = 0;
  int          m_n = 32;
  logic [31:0] m_word = 32'd0;
  logic [31:0] m_pd = 32'd0;
  logic        e_rdy, e_busy, e_ld, e_sv, e_sd, e_done;
  logic [5:0]  e_cnt;

  task automatic model_step(input logic valid, input logic [31:0] data,
                            input logic [5:0] len, input logic abort);
    logic [63:0] mask;
    e_sv = 1'b0; e_sd = 1'b0; e_done = 1'b0; e_cnt = 6'd0;
    if (!m_busy) begin
      if (valid) begin
        m_busy  = 1'b1;
        m_phase = 0;
        m_word  = data;
        m_pd    = data;
        m_n     = (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
      end
    end else if (abort) begin
      m_busy = 1'b0;
    end else begin
      m_phase++;
      e_sv = 1'b1;
      if (m_phase <= m_n) begin
        e_sd  = m_word[m_phase-1];
        e_cnt = 6'(m_phase - 1);
      end else begin
        mask  = (64'd1 << m_n) - 64'd1;
        e_sd  = ^(m_word & mask[31:0]);
        e_cnt = 6'(m_n);
      end
      if (m_phase == m_n + PAR) begin
        e_done = 1'b1;
        m_busy = 1'b0;
      end
    end
    e_rdy  = !m_busy;
    e_busy = m_busy;
    e_ld   = !m_busy || (m_phase == 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  xs_sv, xs_sd;
    int          nq, acc2;

    Reset_In = 1'b1; Tx_Valid_In = 1'b0; Tx_Data_In = 32'd0;
    Frame_Len_In = 6'd0; Abort_In = 1'b0;
    tick();
    check_outs("reset", 1, 0, 1, 0, 0, 0, 6'd0, 32'd0);
    check("reset.sdata", {31'd0, Serial_Data_Out}, 32'd0);
    Reset_In = 1'b0;

    // ---- Vector table ----
    // len 4, data 0xD: bits 1,0,1,1. Frame_Len_In changes after accept.
    vt.push_back(v("len4.r0", 1, 32'hD, 4, 0, 0, 1, 1, 0, 0, 0, 0, 32'hD));
    vt.push_back(v("len4.r1", 0, 32'h0, 2, 0, 0, 1, 0, 1, 1, 0, 0, 32'hD));
    vt.push_back(v("len4.r2", 0, 32'h0, 2, 0, 0, 1, 0, 1, 0, 0, 1, 32'hD));
    vt.push_back(v("len4.r3", 0, 32'h0, 2, 0, 0, 1, 0, 1, 1, 0, 2, 32'hD));
`ifdef PISO_TX_SEQUENCER_PARITY_EN
    vt.push_back(v("len4.r4", 0, 32'h0, 2, 0, 0, 1, 0, 1, 1, 0, 3, 32'hD));
    vt.push_back(v("len4.par", 0, 32'h0, 2, 0, 1, 0, 1, 1, 1, 1, 4, 32'hD));
`else
    vt.push_back(v("len4.r4", 0, 32'h0, 2, 0, 1, 0, 1, 1, 1, 1, 3, 32'hD));
`endif
    vt.push_back(v("len4.idle", 0, 32'h0, 2, 0, 1, 0, 1, 0, 0, 0, 0, 32'hD));
    // len 8, data 0x96, abort while Bit_Count_Out is 2, then abort in IDLE ignored.
    vt.push_back(v("abt.r0", 1, 32'h96, 8, 0, 0, 1, 1, 0, 0, 0, 0, 32'h96));
    vt.push_back(v("abt.r1", 0, 32'h0, 8, 0, 0, 1, 0, 1, 0, 0, 0, 32'h96));
    vt.push_back(v("abt.r2", 0, 32'h0, 8, 0, 0, 1, 0, 1, 1, 0, 1, 32'h96));
    vt.push_back(v("abt.r3", 0, 32'h0, 8, 0, 0, 1, 0, 1, 1, 0, 2, 32'h96));
    vt.push_back(v("abt.cut", 1, 32'h55, 8, 1, 1, 0, 1, 0, 0, 0, 0, 32'h96));
    vt.push_back(v("abt.idle", 1, 32'h3, 2, 1, 0, 1, 1, 0, 0, 0, 0, 32'h3));
    vt.push_back(v("abt.n0", 0, 32'h0, 2, 0, 0, 1, 0, 1, 1, 0, 0, 32'h3));
`ifdef PISO_TX_SEQUENCER_PARITY_EN
    vt.push_back(v("abt.n1", 0, 32'h0, 2, 0, 0, 1, 0, 1, 1, 0, 1, 32'h3));
    vt.push_back(v("abt.par", 0, 32'h0, 2, 0, 1, 0, 1, 1, 0, 1, 2, 32'h3));
`else
    vt.push_back(v("abt.n1", 0, 32'h0, 2, 0, 1, 0, 1, 1, 1, 1, 1, 32'h3));
`endif
    // Abort coincident with the last-bit edge wins.
    vt.push_back(v("abtlast.r0", 1, 32'h3, 2, 0, 0, 1, 1, 0, 0, 0, 0, 32'h3));
    vt.push_back(v("abtlast.r1", 0, 32'h0, 2, 0, 0, 1, 0, 1, 1, 0, 0, 32'h3));
    vt.push_back(v("abtlast.r2", 0, 32'h0, 2, 1, 1, 0, 1, 0, 0, 0, 0, 32'h3));
    // Length 1 boundary.
    vt.push_back(v("len1.r0", 1, 32'h1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h1));
`ifdef PISO_TX_SEQUENCER_PARITY_EN
    vt.push_back(v("len1.r1", 0, 32'h0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 32'h1));
    vt.push_back(v("len1.par", 0, 32'h0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 32'h1));
    // Length 3, data 0x7: bits 1,1,1 then parity 1.
    vt.push_back(v("par3.r0", 1, 32'h7, 3, 0, 0, 1, 1, 0, 0, 0, 0, 32'h7));
    vt.push_back(v("par3.r1", 0, 32'h0, 3, 0, 0, 1, 0, 1, 1, 0, 0, 32'h7));
    vt.push_back(v("par3.r2", 0, 32'h0, 3, 0, 0, 1, 0, 1, 1, 0, 1, 32'h7));
    vt.push_back(v("par3.r3", 0, 32'h0, 3, 0, 0, 1, 0, 1, 1, 0, 2, 32'h7));
    vt.push_back(v("par3.par", 0, 32'h0, 3, 0, 1, 0, 1, 1, 1, 1, 3, 32'h7));
`else
    vt.push_back(v("len1.r1", 0, 32'h0, 1, 0, 1, 0, 1, 1, 1, 1, 0, 32'h1));
`endif

    for (int i = 0; i < vt.size(); i++) begin
      Tx_Valid_In  = vt[i].valid;
      Tx_Data_In   = vt[i].data;
      Frame_Len_In = vt[i].len;
      Abort_In     = vt[i].abort;
      tick();
      check_outs(vt[i].tag, vt[i].e_rdy, vt[i].e_busy, vt[i].e_ld, vt[i].e_sv,
                 vt[i].e_sd, vt[i].e_done, vt[i].e_cnt, vt[i].e_pd);
    end
    Tx_Valid_In = 1'b0; Abort_In = 1'b0;

    // ---- Full 32-bit frame via Frame_Len_In = 0 ----
    w = 32'hA5A50F0F;
    Tx_Valid_In = 1'b1; Tx_Data_In = w; Frame_Len_In = 6'd0;
    tick();
    check("f32.load_ready", {31'd0, Tx_Ready_Out}, 32'd0);
    Tx_Valid_In = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      check($sformatf("f32.valid%0d", k), {31'd0, Serial_Valid_Out}, 32'd1);
      check($sformatf("f32.bit%0d", k),   {31'd0, Serial_Data_Out},  {31'd0, w[k]});
      check($sformatf("f32.cnt%0d", k),   {26'd0, Bit_Count_Out},    k);
      check($sformatf("f32.done%0d", k),  {31'd0, Frame_Done_Out},
            (k == 31 && PAR == 0) ? 32'd1 : 32'd0);
    end
`ifdef PISO_TX_SEQUENCER_PARITY_EN
    tick();
    check("f32.parbit",  {31'd0, Serial_Data_Out}, 32'd0);
    check("f32.pardone", {31'd0, Frame_Done_Out},  32'd1);
    check("f32.parcnt",  {26'd0, Bit_Count_Out},   32);
`endif
    check("f32.ready_after", {31'd0, Tx_Ready_Out}, 32'd1);

    // ---- Back-to-back words with Tx_Valid_In held ----
`ifdef PISO_TX_SEQUENCER_PARITY_EN
    nq = 7; acc2 = 4; xs_sv = 8'b0111_0111; xs_sd = 8'b0110_0101;
`else
    nq = 5; acc2 = 3; xs_sv = 8'b0001_1011; xs_sd = 8'b0001_0001;
`endif
    Tx_Valid_In = 1'b1; Tx_Data_In = 32'h1; Frame_Len_In = 6'd2;
    tick();
    Tx_Data_In = 32'h2;
    for (int i = 1; i <= nq; i++) begin
      tick();
      if (i == acc2) Tx_Valid_In = 1'b0;
      check($sformatf("b2b.valid%0d", i), {31'd0, Serial_Valid_Out}, {31'd0, xs_sv[i-1]});
      if (xs_sv[i-1])
        check($sformatf("b2b.bit%0d", i), {31'd0, Serial_Data_Out}, {31'd0, xs_sd[i-1]});
    end

    // ---- Reset pulsed mid-frame, between edges ----
    Tx_Valid_In = 1'b1; Tx_Data_In = 32'hFFFF_FFFF; Frame_Len_In = 6'd8;
    tick();
    Tx_Valid_In = 1'b0;
    tick(); tick();
    #2;
    Reset_In = 1'b1;
    #1;
    check_outs("rstmid", 1, 0, 1, 0, 0, 0, 6'd0, 32'd0);
    check("rstmid.sdata", {31'd0, Serial_Data_Out}, 32'd0);
    tick();
    Reset_In = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs($sformatf("rstpost%0d", i), 1, 0, 1, 0, 0, 0, 6'd0, 32'd0);
    end

    // ---- Randomised traffic against the reference model ----
    m_busy = 1'b0; m_pd = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      logic        r_valid, r_abort;
      logic [31:0] r_data;
      logic [5:0]  r_len;
      r_valid = 1'($urandom_range(0, 1));
      r_abort = ($urandom_range(0, 15) == 0);
      r_data  = $urandom;
      r_len   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                            : 6'($urandom_range(1, 6));
      Tx_Valid_In = r_valid; Abort_In = r_abort;
      Tx_Data_In = r_data;   Frame_Len_In = r_len;
      tick();
      model_step(r_valid, r_data, r_len, r_abort);
      check_outs($sformatf("rnd%0d", c), e_rdy, e_busy, e_ld, e_sv, e_sd, e_done,
                 e_cnt, m_pd);
    end
    Tx_Valid_In = 1'b0; Abort_In = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
